conv_w_stream: RTL and testbench

Parametrised convolution-weight buffer. It holds an inferred simple-dual-port weight RAM, loaded through a host write port. On command it streams a contiguous run of weights out through a valid/ready interface with backpressure. It sits between the weight loader and the conv PE array, replacing a fixed-width, read-only, always-streaming weight ROM wrapper.

---
 rtl/conv_w_pkg.sv | 13 +
 rtl/conv_w_sdp_ram.sv | 44 ++++
 rtl/conv_w_stream.sv | 155 +++++++++++++++
 tb/tb_conv_w_stream.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_w_pkg.sv
// rtl/conv_w_pkg.sv - shared types and default widths for the conv weight buffer
package conv_w_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/conv_w_sdp_ram.sv
// rtl/conv_w_sdp_ram.sv - simple-dual-port read-first weight RAM with 1 or 2 output stages
module conv_w_sdp_ram #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] q1;

    // Host write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // First read stage; a same-address write lands after this sample, so old data is returned
    always_ff @(posedge clk) begin
        if (rd_en) begin
            q1 <= mem[rd_addr];
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] q2;
        // Optional second output register for timing closure
        always_ff @(posedge clk) begin
            q2 <= q1;
        end
        assign rd_data = q2;
    end else begin : g_lat1
        assign rd_data = q1;
    end

endmodule

// File: rtl/conv_w_stream.sv
// rtl/conv_w_stream.sv - weight buffer streaming contiguous bursts with backpressure
module conv_w_stream
    import conv_w_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = PW + 2;
    localparam int RW = ADDR_W + 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [RW-1:0]     remain;
    logic              rd_en, rd_last, credit_ok;
    logic [DATA_W-1:0] ram_q;
    logic [RD_LAT-1:0] vld_pipe, last_pipe;
    logic              push, push_last, pop;
    logic [CW-1:0]     fifo_count, inflight;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;

    // Reads are only issued when a FIFO slot is guaranteed for the returning word
    assign credit_ok = (SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH);
    assign rd_last   = (remain == RW'(1));
    assign cmd_rdy   = (state == IDLE);
    assign busy      = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and read-issue decode
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_vld && (cmd_len != '0)) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    if (rd_last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst address and remaining-word counter; address wraps naturally at 2**ADDR_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr <= '0;
            remain  <= '0;
        end else if ((state == IDLE) && cmd_vld) begin
            rd_addr <= cmd_base;
            remain  <= cmd_len;
        end else if (rd_en) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            remain  <= remain - RW'(1);
        end
    end

    conv_w_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Valid and last tags travel alongside the RAM read pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= rd_en;
            last_pipe[0] <= rd_en & rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    assign push      = vld_pipe[RD_LAT-1];
    assign push_last = last_pipe[RD_LAT-1];

    // Reads issued but not yet landed in the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight <= '0;
        else     inflight <= inflight + CW'(rd_en) - CW'(push);
    end

    // FIFO pointers, occupancy and last flags; reset discards buffered words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_last  <= '0;
        end else begin
            if (push) begin
                fifo_last[wr_ptr] <= push_last;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // FIFO data storage; stale entries are masked by out_vld
    always_ff @(posedge clk) begin
        if (push) fifo_data[wr_ptr] <= ram_q;
    end

    assign out_vld  = (fifo_count != '0);
    assign pop      = out_vld & out_rdy;
    assign out_data = out_vld ? fifo_data[rd_ptr] : '0;
    assign out_last = out_vld & fifo_last[rd_ptr];

endmodule

// File: tb/tb_conv_w_stream.sv
// tb/tb_conv_w_stream.sv - scoreboard bench for conv_w_stream at RD_LAT 1 and 2
module tb_conv_w_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        cmd_vld = 1'b0, cmd_rdy;
    logic [11:0] cmd_base = '0;
    logic [12:0] cmd_len = '0;
    logic        out_vld, out_rdy = 1'b1, out_last, busy;
    logic [23:0] out_data;

    logic        cmd_vld2 = 1'b0, cmd_rdy2;
    logic [11:0] cmd_base2 = '0;
    logic [12:0] cmd_len2 = '0;
    logic        out_vld2, out_last2, busy2;
    logic        out_rdy2 = 1'b1;
    logic [23:0] out_data2;

    int n_cmp = 0;
    int n_err = 0;
    int hs_count = 0;
    logic [23:0] model [4096];
    logic [24:0] exp_q [$];
    logic [24:0] exp2_q [$];

    always #5 clk = ~clk;

    conv_w_stream #(.DATA_W(24), .ADDR_W(12), .RD_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
        .busy(busy)
    );

    conv_w_stream #(.DATA_W(24), .ADDR_W(12), .RD_LAT(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_vld(cmd_vld2), .cmd_rdy(cmd_rdy2), .cmd_base(cmd_base2), .cmd_len(cmd_len2),
        .out_vld(out_vld2), .out_rdy(out_rdy2), .out_data(out_data2), .out_last(out_last2),
        .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [11:0] base, input logic [12:0] len, input bit second);
        logic [11:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 12'(i);
            if (second) exp2_q.push_back({(i == int'(len) - 1), model[a]});
            else        exp_q.push_back({(i == int'(len) - 1), model[a]});
        end
    endtask

    task automatic issue_cmd(input logic [11:0] base, input logic [12:0] len);
        int t = 0;
        while (!cmd_rdy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("cmd_rdy_wait", {31'd0, cmd_rdy}, 32'd1);
        push_exp(base, len, 1'b0);
        cmd_vld = 1'b1; cmd_base = base; cmd_len = len;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk(name, {31'd0, (t < 300)}, 32'd1);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard for the RD_LAT=1 instance, including hold-while-stalled checks
    logic        stall_prev = 1'b0;
    logic [24:0] prev_word = '0;
    always @(negedge clk) begin
        logic [24:0] e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_vld", {31'd0, out_vld}, 32'd1);
                chk("hold_word", {7'd0, out_last, out_data}, {7'd0, prev_word});
            end
            if (out_vld && out_rdy) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL extra_word: got %h expected none", {out_last, out_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {7'd0, out_last, out_data}, {7'd0, e});
                end
            end
            stall_prev = out_vld && !out_rdy;
            prev_word  = {out_last, out_data};
        end
    end

    // Scoreboard for the RD_LAT=2 instance
    always @(negedge clk) begin
        logic [24:0] e;
        if (!rst && out_vld2 && out_rdy2) begin
            if (exp2_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL extra_word2: got %h expected none", {out_last2, out_data2});
            end else begin
                e = exp2_q.pop_front();
                chk("word2", {7'd0, out_last2, out_data2}, {7'd0, e});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, saw, hs_base;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_data", {8'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        for (int n = 0; n < 4096; n++) begin
            wr_en = 1'b1; wr_addr = 12'(n); wr_data = 24'(n + 'h100);
            model[n] = 24'(n + 'h100);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;

        // Basic burst on both instances; latency checked per RD_LAT
        push_exp(12'h010, 13'd5, 1'b0);
        push_exp(12'h010, 13'd5, 1'b1);
        cmd_vld = 1'b1; cmd_base = 12'h010; cmd_len = 13'd5;
        cmd_vld2 = 1'b1; cmd_base2 = 12'h010; cmd_len2 = 13'd5;
        @(posedge clk); #1;
        cmd_vld = 1'b0; cmd_vld2 = 1'b0;
        chk("lat_e0", {30'd0, out_vld, out_vld2}, 32'd0);
        chk("busy_after_cmd", {30'd0, busy, busy2}, 32'd3);
        @(posedge clk); #1;
        chk("lat_e1", {30'd0, out_vld, out_vld2}, 32'd0);
        @(posedge clk); #1;
        chk("lat_e2", {30'd0, out_vld, out_vld2}, 32'd2);
        @(posedge clk); #1;
        chk("lat_e3_rd2", {31'd0, out_vld2}, 32'd1);
        wait_idle("burst1");
        t = 0;
        while ((busy2 || exp2_q.size() != 0) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("burst1_rd2_done", {31'd0, (t < 100)}, 32'd1);

        // Address wrap
        issue_cmd(12'hFFE, 13'd4);
        wait_idle("wrap");

        // Long stall, FIFO fill, then toggling ready
        out_rdy = 1'b0;
        issue_cmd(12'h300, 13'd8);
        repeat (20) begin @(posedge clk); #1; end
        chk("stall_fifo_full", 32'(dut.fifo_count), 32'd4);
        chk("stall_no_inflight", 32'(dut.inflight), 32'd0);
        chk("stall_queue", exp_q.size(), 32'd8);
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 100) begin
            out_rdy = ~out_rdy;
            @(posedge clk); #1;
            t++;
        end
        out_rdy = 1'b1;
        chk("stall_done", {31'd0, (t < 100)}, 32'd1);

        // Zero-length command, then a one-word command on the next cycle
        issue_cmd(12'h050, 13'd0);
        chk("len0_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        chk("len0_vld", {31'd0, out_vld}, 32'd0);
        issue_cmd(12'h060, 13'd1);
        chk("len1_busy", {31'd0, busy}, 32'd1);
        wait_idle("len1");

        // Write colliding with the read of the same address returns old data
        issue_cmd(12'h020, 13'd1);
        wr_en = 1'b1; wr_addr = 12'h020; wr_data = 24'hABCDEF;
        @(posedge clk); #1;
        wr_en = 1'b0;
        model[12'h020] = 24'hABCDEF;
        wait_idle("collide_old");
        issue_cmd(12'h020, 13'd1);
        wait_idle("collide_new");

        // Reset after three of ten words
        hs_base = hs_count;
        issue_cmd(12'h200, 13'd10);
        t = 0;
        while (hs_count < hs_base + 3 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("words_before_rst", 32'(hs_count - hs_base), 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", {31'd0, out_vld}, 32'd0);
        chk("mid_rst_last", {31'd0, out_last}, 32'd0);
        chk("mid_rst_data", {8'd0, out_data}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        saw = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_vld) saw++;
        end
        chk("no_vld_after_rst", saw, 32'd0);
        issue_cmd(12'h400, 13'd2);
        wait_idle("post_rst");

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
